float_result_sequencer: RTL and testbench
=========================================

FLOAT_RESULT_SEQUENCER -- requirements
Module: float_result_sequencer

Interface
REQ-001 Parameter N_UNITS, default 4: number of FP execution units merged (2..8).
REQ-002 Parameter DEPTH, default 4: maximum outstanding operations (power of two, 2..16).
REQ-003 Parameter IN_ORDER, default 1: 1 = results leave in issue order; 0 = round-robin among ready units.
REQ-004 Parameter RES_W, default 43: width of one result bundle (float_pkg::fp_result_t).
REQ-005 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port flush  in  1  synchronous discard of all outstanding tags.
REQ-008 Port issue_valid  in  1  an operation is being issued to a unit.
REQ-009 Port issue_ready  out  1  sequencer can record another operation.
REQ-010 Port issue_unit  in  $clog2(N_UNITS)  index of the unit receiving the operation.
REQ-011 Port unit_valid  in  N_UNITS  per-unit result valid.
REQ-012 Port unit_ready  out  N_UNITS  per-unit result accept, driven into each unit's ready_in.
REQ-013 Port unit_data  in  N_UNITS*RES_W  packed result bundles; unit i at bits [i*RES_W +: RES_W].
REQ-014 Port valid_out  out  1  selected result valid toward post_processor.
REQ-015 Port ready_in  in  1  post_processor accept.
REQ-016 Port data_out  out  RES_W  selected result bundle.
REQ-017 Port outstanding  out  $clog2(DEPTH)+1  number of recorded, not yet retired operations.

Function
REQ-018 Issue handshake SHALL fire when issue_valid && issue_ready; issue_ready = (outstanding < DEPTH) && !flush && (issue_unit < N_UNITS).
REQ-019 Each fired issue SHALL push issue_unit into a tag FIFO of DEPTH entries; write pointer wraps modulo DEPTH.
REQ-020 IN_ORDER=1: head tag h selects the unit; valid_out = (outstanding != 0) && unit_valid[h]; data_out = unit_data[h]; unit_ready[h] = ready_in && outstanding != 0; all other unit_ready bits 0.
REQ-021 IN_ORDER=1: a valid result from a non-head unit SHALL be held (unit_ready low) until its tag reaches the head.
REQ-022 IN_ORDER=0: grant SHALL be the first i with unit_valid[i], searching from pointer rr upward modulo N_UNITS; after a transfer from unit g, rr = (g+1) mod N_UNITS; FIFO used only for counting.
REQ-023 Retire SHALL occur when valid_out && ready_in; it pops the FIFO head (read pointer wraps modulo DEPTH).
REQ-024 Output path SHALL be combinational (zero cycles from unit_valid to valid_out); recorded tag is usable the cycle after issue.
REQ-025 Issue and retire in the same cycle SHALL leave outstanding unchanged; full FIFO with simultaneous retire SHALL still deassert issue_ready that cycle.
REQ-026 data_out SHALL be 0 whenever valid_out is 0.
REQ-027 flush SHALL force valid_out=0 and unit_ready=0 in that cycle and clear pointers, outstanding and rr at the edge; flush outranks issue and retire.
REQ-028 valid_out, once high, SHALL stay high with stable data_out until ready_in (units hold their outputs).

Reset
REQ-029 reset SHALL clear read/write pointers, outstanding and rr to 0; valid_out, unit_ready, data_out read 0 and issue_ready reads 1 (valid index, no flush) in the cycle after reset.
REQ-030 reset mid-operation SHALL drop all tags; results still presented by units are not forwarded.
REQ-031 reset SHALL take priority over flush, issue and retire.

Structure
REQ-032 float_pkg SHALL hold fp_result_t (man 24, exp 10, sgn, round_bit, sticky_bit, skip_round, IV, DZ, rm 3 = 43 bits) and unit index constants UNIT_ADD=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_SQRT=3.
REQ-033 Tag storage SHALL be one sub-module tag_fifo (parametrised DEPTH, width $clog2(N_UNITS)); arbitration lives in the top.

Verification
REQ-034 IN_ORDER=1: issue DIV(2) then ADD(0); ADD valid cycle 3, DIV valid cycle 10 -> unit_ready[0] low until DIV retires at cycle 10, ADD retires cycle 11; outstanding 2->1->0.
REQ-035 DEPTH=4: issue 4 ops with ready_in=0 -> outstanding=4, issue_ready=0; retire one with issue_valid high the same cycle -> no issue that cycle, issue accepted next cycle, outstanding=4.
REQ-036 IN_ORDER=0, units 1 and 3 valid continuously, ready_in=1 -> grants 1,3,1,3; rr reads 2,0,2,0.
REQ-037 Three ops outstanding, flush pulsed while unit 0 valid -> valid_out=0 that cycle, outstanding=0 next cycle, later unit 0 result not forwarded.
REQ-038 issue_unit=5 with N_UNITS=4 -> issue_ready=0, outstanding unchanged.
REQ-039 reset asserted with 2 ops outstanding and ready_in=1 -> outstanding=0, valid_out=0, issue_ready=1 next cycle.

Source files
------------

// File: rtl/float_pkg.sv
// float_pkg
// Shared types and constants for the floating-point result path.
//   fp_result_t : 43-bit result bundle produced by every FP execution unit
//   UNIT_*      : execution unit indices as seen on issue_unit / unit_valid
//   idxWidth()  : width of an index able to address n units (at least 1 bit)
package float_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } round_mode_e;

  typedef struct packed {
    logic [23:0] man;
    logic [9:0]  exp;
    logic        sgn;
    logic        round_bit;
    logic        sticky_bit;
    logic        skip_round;
    logic        IV;
    logic        DZ;
    logic [2:0]  rm;
  } fp_result_t;

  localparam int FP_RESULT_W = $bits(fp_result_t);

  localparam int UNIT_ADD  = 0;
  localparam int UNIT_MUL  = 1;
  localparam int UNIT_DIV  = 2;
  localparam int UNIT_SQRT = 3;

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/float_result_sequencer_if.sv
// float_result_sequencer_if
// Bundles the issue side, the per-unit result side and the merged output
// side of the result sequencer.
//   master : environment (issuer, execution units, post_processor)
//   slave  : the sequencer itself
//   flush, issue_valid/issue_ready/issue_unit, unit_valid/unit_ready/unit_data,
//   valid_out/ready_in/data_out, outstanding
interface float_result_sequencer_if
  import float_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int DEPTH   = 4,
  parameter int RES_W   = FP_RESULT_W
) ();

  localparam int UW = idxWidth(N_UNITS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     flush;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [UW-1:0]            issue_unit;
  logic [N_UNITS-1:0]       unit_valid;
  logic [N_UNITS-1:0]       unit_ready;
  logic [N_UNITS*RES_W-1:0] unit_data;
  logic                     valid_out;
  logic                     ready_in;
  logic [RES_W-1:0]         data_out;
  logic [CW-1:0]            outstanding;

  modport master (
    output flush, issue_valid, issue_unit, unit_valid, unit_data, ready_in,
    input  issue_ready, unit_ready, valid_out, data_out, outstanding
  );

  modport slave (
    input  flush, issue_valid, issue_unit, unit_valid, unit_data, ready_in,
    output issue_ready, unit_ready, valid_out, data_out, outstanding
  );

endinterface

// File: rtl/float_result_sequencer_tag_fifo.sv
// tag_fifo
// Circular FIFO of unit tags, one entry per operation still in flight.
//   clk, reset : clock and synchronous active-high reset
//   flush      : discards every stored tag at the edge
//   push       : store pushTag (caller guarantees the FIFO is not full)
//   pop        : drop the head entry (caller guarantees it is not empty)
//   headTag    : oldest stored tag
//   count      : number of stored tags, 0..DEPTH
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           pushTag,
  input  logic                   pop,
  output logic [W-1:0]           headTag,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW:0]   count_q, count_d;

  // Pointer and occupancy update. DEPTH is a power of two, so the
  // pointers wrap simply by overflowing. A push and a pop in the same
  // cycle leave the occupancy unchanged; flush empties everything.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register for pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Tag storage. Entries are never read unless counted as valid, so the
  // array itself needs no reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      mem_q[wrPtr_q] <= pushTag;
    end
  end

  assign headTag = mem_q[rdPtr_q];
  assign count   = count_q;

endmodule

// File: rtl/float_result_sequencer.sv
// float_result_sequencer
// Merges the result streams of N_UNITS FP execution units into a single
// stream toward the post_processor. Every issued operation records its unit
// in a tag FIFO. With IN_ORDER=1 only the unit named by the oldest tag may
// deliver; with IN_ORDER=0 ready units are served round-robin and the FIFO
// only tracks how many operations are in flight.
//   clk, reset : clock, synchronous active-high reset
//   bus.flush  : drop all outstanding operations
//   bus.issue_valid/issue_ready/issue_unit : operation issue handshake
//   bus.unit_valid/unit_ready/unit_data    : per-unit result handshakes
//   bus.valid_out/ready_in/data_out        : merged result handshake
//   bus.outstanding                        : operations not yet retired
module float_result_sequencer
  import float_pkg::*;
#(
  parameter int N_UNITS  = 4,
  parameter int DEPTH    = 4,
  parameter int IN_ORDER = 1,
  parameter int RES_W    = FP_RESULT_W
) (
  input logic                     clk,
  input logic                     reset,
  float_result_sequencer_if.slave bus
);

  localparam int UW = idxWidth(N_UNITS);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [RES_W-1:0]   unitData [N_UNITS];
  logic [UW-1:0]      headTag;
  logic [CW-1:0]      count;
  logic               issueReady;
  logic               issueFire;
  logic               retire;
  logic [UW-1:0]      grantIdx;
  logic               grantValid;
  logic               validOut;
  logic [RES_W-1:0]   dataOut;
  logic [N_UNITS-1:0] unitReady;
  logic [UW-1:0]      rrPtr_q, rrPtr_d;

  // Split the packed result bus into one bundle per unit.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      unitData[i] = bus.unit_data[i*RES_W +: RES_W];
    end
  end

  // Issue acceptance. Only the occupancy is compared against DEPTH, so a
  // full FIFO refuses an issue even when a retire frees a slot this cycle.
  always_comb begin
    issueReady = (count < CW'(DEPTH)) && !bus.flush &&
                 ({1'b0, bus.issue_unit} < (UW+1)'(N_UNITS));
    issueFire  = bus.issue_valid && issueReady;
  end

  // Selection of the unit allowed to deliver. In order, the head tag alone
  // decides. Round-robin searches upward from rrPtr_q and wraps, so the
  // unit just served drops to lowest priority.
  always_comb begin
    int cand;
    cand       = 0;
    grantValid = 1'b0;
    grantIdx   = '0;
    if (IN_ORDER != 0) begin
      grantIdx   = headTag;
      grantValid = bus.unit_valid[headTag];
    end else begin
      for (int k = 0; k < N_UNITS; k++) begin
        cand = (int'(rrPtr_q) + k) % N_UNITS;
        if (!grantValid && bus.unit_valid[cand]) begin
          grantValid = 1'b1;
          grantIdx   = UW'(cand);
        end
      end
    end
  end

  // Merged output path, purely combinational. Nothing is forwarded while
  // flushing or when no operation is in flight, so stale unit results never
  // leak out. In order, the head unit sees ready_in even before it is
  // valid; the other units are held off until their tag reaches the head.
  always_comb begin
    validOut  = 1'b0;
    dataOut   = '0;
    unitReady = '0;
    if (!bus.flush && (count != '0)) begin
      validOut = grantValid;
      if (IN_ORDER != 0 || grantValid) begin
        unitReady[grantIdx] = bus.ready_in;
      end
      if (grantValid) begin
        dataOut = unitData[grantIdx];
      end
    end
    retire = validOut && bus.ready_in;
  end

  // Round-robin pointer next state: moves just past the unit that
  // transferred, restarts from unit 0 on flush.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (bus.flush) begin
      rrPtr_d = '0;
    end else if (IN_ORDER == 0 && retire) begin
      rrPtr_d = (int'(grantIdx) == N_UNITS - 1) ? '0 : grantIdx + UW'(1);
    end
  end

  // Round-robin pointer register; reset outranks everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

  tag_fifo #(
    .DEPTH (DEPTH),
    .W     (UW)
  ) uTagFifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .push    (issueFire),
    .pushTag (bus.issue_unit),
    .pop     (retire),
    .headTag (headTag),
    .count   (count)
  );

  assign bus.issue_ready = issueReady;
  assign bus.valid_out   = validOut;
  assign bus.data_out    = dataOut;
  assign bus.unit_ready  = unitReady;
  assign bus.outstanding = count;

endmodule

// File: tb/tb_float_result_sequencer.sv
// tb_float_result_sequencer
// dutA: 4 units, DEPTH 4, in order. dutB: 4 units, DEPTH 4, round-robin.
// dutC: 5 units, in order, used only for the out-of-range unit index case
// (index 5 is not representable on a 2-bit issue_unit).
// A queue/counter model of dutA and dutB is checked every cycle on the
// falling edge; directed sequences add hand-computed literal checks.
`timescale 1ns/1ps
module tb_float_result_sequencer;
  import float_pkg::*;

  localparam int RW = FP_RESULT_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  float_result_sequencer_if #(.N_UNITS(4), .DEPTH(4), .RES_W(RW)) ifA ();
  float_result_sequencer_if #(.N_UNITS(4), .DEPTH(4), .RES_W(RW)) ifB ();
  float_result_sequencer_if #(.N_UNITS(5), .DEPTH(4), .RES_W(RW)) ifC ();

  float_result_sequencer #(.N_UNITS(4), .DEPTH(4), .IN_ORDER(1), .RES_W(RW))
    dutA (.clk(clk), .reset(reset), .bus(ifA));
  float_result_sequencer #(.N_UNITS(4), .DEPTH(4), .IN_ORDER(0), .RES_W(RW))
    dutB (.clk(clk), .reset(reset), .bus(ifB));
  float_result_sequencer #(.N_UNITS(5), .DEPTH(4), .IN_ORDER(1), .RES_W(RW))
    dutC (.clk(clk), .reset(reset), .bus(ifC));

  int testsRun  = 0;
  int failCount = 0;
  bit checkEn   = 1'b0;

  int qA[$];
  int cntB = 0;
  int rrB  = 0;

  // Distinct recognisable result bundle per unit.
  function automatic logic [RW-1:0] unitWord(input int i);
    fp_result_t r;
    r      = '0;
    r.man  = 24'hC0DE00 + 24'(i);
    r.exp  = 10'h155 ^ 10'(i);
    r.sgn  = 1'(i & 1);
    r.IV   = 1'(i == UNIT_DIV);
    r.rm   = 3'(i);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive dutA's inputs for one cycle, just after the rising edge.
  task automatic applyStimulus(input logic iv, input logic [1:0] iu,
                               input logic [3:0] uv, input logic ri,
                               input logic fl);
    @(posedge clk);
    #1;
    ifA.issue_valid = iv;
    ifA.issue_unit  = iu;
    ifA.unit_valid  = uv;
    ifA.ready_in    = ri;
    ifA.flush       = fl;
  endtask

  task automatic applyB(input logic iv, input logic [1:0] iu,
                        input logic [3:0] uv, input logic ri);
    @(posedge clk);
    #1;
    ifB.issue_valid = iv;
    ifB.issue_unit  = iu;
    ifB.unit_valid  = uv;
    ifB.ready_in    = ri;
  endtask

  // Every-cycle comparison against the model, then the model advances by
  // whatever the current inputs will cause at the next rising edge.
  always @(negedge clk) begin : compareProc
    logic          expIr;
    logic          expV;
    logic [3:0]    expUr;
    logic [RW-1:0] expD;
    int            g;
    if (checkEn) begin
      expIr = (qA.size() < 4) && !ifA.flush && (int'(ifA.issue_unit) < 4);
      expV  = 1'b0;
      expUr = '0;
      expD  = '0;
      if (!ifA.flush && qA.size() > 0) begin
        expUr[qA[0]] = ifA.ready_in;
        expV         = ifA.unit_valid[qA[0]];
        if (expV) expD = unitWord(qA[0]);
      end
      checkOutput("A.issue_ready", 64'(ifA.issue_ready), 64'(expIr));
      checkOutput("A.valid_out",   64'(ifA.valid_out),   64'(expV));
      checkOutput("A.data_out",    64'(ifA.data_out),    64'(expD));
      checkOutput("A.unit_ready",  64'(ifA.unit_ready),  64'(expUr));
      checkOutput("A.outstanding", 64'(ifA.outstanding), 64'(qA.size()));
      if (reset || ifA.flush) begin
        qA.delete();
      end else begin
        if (expV && ifA.ready_in) void'(qA.pop_front());
        if (ifA.issue_valid && expIr) qA.push_back(int'(ifA.issue_unit));
      end

      expIr = (cntB < 4) && !ifB.flush;
      expV  = 1'b0;
      expUr = '0;
      expD  = '0;
      g     = -1;
      if (!ifB.flush && cntB > 0) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && ifB.unit_valid[(rrB + k) % 4]) g = (rrB + k) % 4;
        end
      end
      if (g >= 0) begin
        expV     = 1'b1;
        expD     = unitWord(g);
        expUr[g] = ifB.ready_in;
      end
      checkOutput("B.issue_ready", 64'(ifB.issue_ready), 64'(expIr));
      checkOutput("B.valid_out",   64'(ifB.valid_out),   64'(expV));
      checkOutput("B.data_out",    64'(ifB.data_out),    64'(expD));
      checkOutput("B.unit_ready",  64'(ifB.unit_ready),  64'(expUr));
      checkOutput("B.outstanding", 64'(ifB.outstanding), 64'(cntB));
      if (reset || ifB.flush) begin
        cntB = 0;
        rrB  = 0;
      end else begin
        if (expV && ifB.ready_in) begin
          cntB--;
          rrB = (g + 1) % 4;
        end
        if (ifB.issue_valid && expIr) cntB++;
      end
    end
  end

  initial begin
    int expG [4] = '{1, 3, 1, 3};
    int expRr[4] = '{2, 0, 2, 0};

    reset = 1'b1;
    ifA.flush = 0; ifA.issue_valid = 0; ifA.issue_unit = 0;
    ifA.unit_valid = 0; ifA.ready_in = 0;
    ifA.unit_data = {unitWord(3), unitWord(2), unitWord(1), unitWord(0)};
    ifB.flush = 0; ifB.issue_valid = 0; ifB.issue_unit = 0;
    ifB.unit_valid = 0; ifB.ready_in = 0;
    ifB.unit_data = {unitWord(3), unitWord(2), unitWord(1), unitWord(0)};
    ifC.flush = 0; ifC.issue_valid = 0; ifC.issue_unit = 0;
    ifC.unit_valid = 0; ifC.ready_in = 0; ifC.unit_data = '0;

    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    checkOutput("rst.valid_out",   64'(ifA.valid_out),   64'd0);
    checkOutput("rst.unit_ready",  64'(ifA.unit_ready),  64'd0);
    checkOutput("rst.data_out",    64'(ifA.data_out),    64'd0);
    checkOutput("rst.issue_ready", 64'(ifA.issue_ready), 64'd1);
    checkOutput("rst.outstanding", 64'(ifA.outstanding), 64'd0);

    // DIV issued before ADD; ADD finishes first but must wait.
    applyStimulus(1, 2'd2, 4'b0000, 1, 0);
    applyStimulus(1, 2'd0, 4'b0000, 1, 0);
    applyStimulus(0, 2'd0, 4'b0000, 1, 0);
    applyStimulus(0, 2'd0, 4'b0001, 1, 0);
    #2;
    checkOutput("ord.add_held",    64'(ifA.unit_ready),  64'b0100);
    checkOutput("ord.no_valid",    64'(ifA.valid_out),   64'd0);
    checkOutput("ord.outst2",      64'(ifA.outstanding), 64'd2);
    repeat (6) applyStimulus(0, 2'd0, 4'b0001, 1, 0);
    applyStimulus(0, 2'd0, 4'b0101, 1, 0);
    #2;
    checkOutput("ord.div_valid",   64'(ifA.valid_out),   64'd1);
    checkOutput("ord.div_data",    64'(ifA.data_out),    64'(unitWord(2)));
    checkOutput("ord.div_ready",   64'(ifA.unit_ready),  64'b0100);
    applyStimulus(0, 2'd0, 4'b0001, 1, 0);
    #2;
    checkOutput("ord.outst1",      64'(ifA.outstanding), 64'd1);
    checkOutput("ord.add_ready",   64'(ifA.unit_ready),  64'b0001);
    checkOutput("ord.add_data",    64'(ifA.data_out),    64'(unitWord(0)));
    applyStimulus(0, 2'd0, 4'b0000, 1, 0);
    #2;
    checkOutput("ord.outst0",      64'(ifA.outstanding), 64'd0);
    checkOutput("ord.idle_valid",  64'(ifA.valid_out),   64'd0);

    // Fill to DEPTH, then retire with an issue pending in the same cycle.
    for (int u = 0; u < 4; u++) applyStimulus(1, 2'(u), 4'b0000, 0, 0);
    applyStimulus(0, 2'd0, 4'b0000, 0, 0);
    #2;
    checkOutput("full.outst",      64'(ifA.outstanding), 64'd4);
    checkOutput("full.issue_rdy",  64'(ifA.issue_ready), 64'd0);
    applyStimulus(1, 2'd1, 4'b0001, 1, 0);
    #2;
    checkOutput("full.ret_irdy",   64'(ifA.issue_ready), 64'd0);
    checkOutput("full.ret_valid",  64'(ifA.valid_out),   64'd1);
    applyStimulus(1, 2'd1, 4'b0000, 0, 0);
    #2;
    checkOutput("full.outst3",     64'(ifA.outstanding), 64'd3);
    checkOutput("full.irdy_next",  64'(ifA.issue_ready), 64'd1);
    applyStimulus(0, 2'd0, 4'b0000, 0, 0);
    #2;
    checkOutput("full.outst4",     64'(ifA.outstanding), 64'd4);
    repeat (4) applyStimulus(0, 2'd0, 4'b1111, 1, 0);
    applyStimulus(0, 2'd0, 4'b0000, 0, 0);
    #2;
    checkOutput("full.drained",    64'(ifA.outstanding), 64'd0);

    // Flush with three operations in flight and unit 0 presenting.
    for (int u = 0; u < 3; u++) applyStimulus(1, 2'(u), 4'b0000, 0, 0);
    applyStimulus(0, 2'd0, 4'b0001, 1, 1);
    #2;
    checkOutput("fl.valid_out",    64'(ifA.valid_out),   64'd0);
    checkOutput("fl.unit_ready",   64'(ifA.unit_ready),  64'd0);
    checkOutput("fl.issue_ready",  64'(ifA.issue_ready), 64'd0);
    checkOutput("fl.outst3",       64'(ifA.outstanding), 64'd3);
    applyStimulus(0, 2'd0, 4'b0001, 1, 0);
    #2;
    checkOutput("fl.outst0",       64'(ifA.outstanding), 64'd0);
    checkOutput("fl.no_fwd",       64'(ifA.valid_out),   64'd0);
    applyStimulus(0, 2'd0, 4'b0001, 1, 0);
    #2;
    checkOutput("fl.no_fwd2",      64'(ifA.valid_out),   64'd0);
    checkOutput("fl.ur_zero",      64'(ifA.unit_ready),  64'd0);
    applyStimulus(0, 2'd0, 4'b0000, 0, 0);

    // Reset with two operations in flight and the head unit presenting.
    applyStimulus(1, 2'd3, 4'b0000, 1, 0);
    applyStimulus(1, 2'd1, 4'b0000, 1, 0);
    applyStimulus(0, 2'd0, 4'b1000, 1, 0);
    reset = 1'b1;
    #2;
    checkOutput("rs.outst2",       64'(ifA.outstanding), 64'd2);
    applyStimulus(0, 2'd0, 4'b1000, 1, 0);
    reset = 1'b0;
    #2;
    checkOutput("rs.outst0",       64'(ifA.outstanding), 64'd0);
    checkOutput("rs.valid_out",    64'(ifA.valid_out),   64'd0);
    checkOutput("rs.issue_ready",  64'(ifA.issue_ready), 64'd1);
    checkOutput("rs.unit_ready",   64'(ifA.unit_ready),  64'd0);
    applyStimulus(0, 2'd0, 4'b0000, 0, 0);

    // Round-robin between units 1 and 3, both valid continuously.
    applyB(1, 2'd1, 4'b0000, 0);
    applyB(1, 2'd3, 4'b0000, 0);
    applyB(1, 2'd1, 4'b0000, 0);
    applyB(1, 2'd3, 4'b0000, 0);
    for (int k = 0; k < 4; k++) begin
      applyB(0, 2'd0, 4'b1010, 1);
      #2;
      if (k > 0) checkOutput("rr.ptr", 64'(dutB.rrPtr_q), 64'(expRr[k-1]));
      checkOutput("rr.grant", 64'(ifB.unit_ready), 64'(4'b0001 << expG[k]));
      checkOutput("rr.data",  64'(ifB.data_out),   64'(unitWord(expG[k])));
    end
    applyB(0, 2'd0, 4'b1010, 1);
    #2;
    checkOutput("rr.ptr_last",     64'(dutB.rrPtr_q),    64'(expRr[3]));
    checkOutput("rr.outst0",       64'(ifB.outstanding), 64'd0);
    checkOutput("rr.idle_valid",   64'(ifB.valid_out),   64'd0);
    applyB(0, 2'd0, 4'b0000, 0);

    // Unit index outside N_UNITS is refused.
    @(posedge clk);
    #1;
    ifC.issue_valid = 1'b1;
    ifC.issue_unit  = 3'd5;
    #2;
    checkOutput("idx.bad_ready",   64'(ifC.issue_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("idx.bad_outst",   64'(ifC.outstanding), 64'd0);
    ifC.issue_unit = 3'd4;
    #2;
    checkOutput("idx.ok_ready",    64'(ifC.issue_ready), 64'd1);
    @(posedge clk);
    #1;
    ifC.issue_valid = 1'b0;
    #2;
    checkOutput("idx.ok_outst",    64'(ifC.outstanding), 64'd1);

    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
